// File: rtl/fetch_decode_seq.sv
// Instruction fetch/decode sequencer: loadable instruction memory, internal PC,
// in-band jump/halt opcodes, valid/ready output with backpressure.
module fetch_decode_seq #(
  parameter int                INST_CAP = 32,
  parameter int                OP_LEN   = 4,
  parameter int                DATA_LEN = 8,
  parameter logic [OP_LEN-1:0] JMP_OP   = 4'hE,
  parameter logic [OP_LEN-1:0] HALT_OP  = 4'hF,
  localparam int               INST_LEN = OP_LEN + DATA_LEN,
  localparam int               PC_W     = $clog2(INST_CAP)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                ld_we,
  input  logic [PC_W-1:0]     ld_addr,
  input  logic [INST_LEN-1:0] ld_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_LEN-1:0]   op,
  output logic [DATA_LEN-1:0] data,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, HOLD, HALT} state_t;

  typedef struct packed {
    logic [OP_LEN-1:0]   op;
    logic [DATA_LEN-1:0] data;
  } inst_t;

  state_t              state_q, state_d;
  inst_t               mem [INST_CAP];
  inst_t               inst_q, inst_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [OP_LEN-1:0]   op_q, op_d;
  logic [DATA_LEN-1:0] data_q, data_d;
  logic                err_q, err_d;
  logic                stopped;
  logic                ld_ok;
  logic                jmp_ok;

  assign stopped = (state_q == IDLE) || (state_q == HALT);
  // Non-power-of-two depths leave addressable holes; writes there are dropped.
  assign ld_ok   = ld_we && stopped && (32'(ld_addr) < INST_CAP);
  // Whole data field must name a real word, so stray upper bits also fail.
  assign jmp_ok  = 32'(inst_q.data) < INST_CAP;

  always_ff @(posedge clk) begin
    if (ld_ok) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE, HALT: begin
        if (en) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        inst_d  = mem[pc_q];
        state_d = DECODE;
      end
      DECODE: begin
        if (inst_q.op == HALT_OP) begin
          state_d = HALT;
        end else if (inst_q.op == JMP_OP) begin
          if (jmp_ok) begin
            pc_d    = inst_q.data[PC_W-1:0];
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = HALT;
          end
        end else begin
          op_d    = inst_q.op;
          data_d  = inst_q.data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          pc_d    = (pc_q == PC_W'(INST_CAP - 1)) ? '0 : pc_q + PC_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= '0;
      inst_q <= '0;
      op_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      inst_q <= inst_d;
      op_q   <= op_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  // Output valid and status flags are pure state decodes, so async reset clears them at once.
  assign out_valid = (state_q == HOLD);
  assign busy      = !stopped;
  assign halted    = (state_q == HALT);
  assign op        = op_q;
  assign data      = data_q;
  assign pc        = pc_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fetch_decode_seq.sv
// Directed bench for fetch_decode_seq: scoreboard queue per DUT popped by a
// negedge monitor on every handshake, plus directed status/timing checks.
module tb_fetch_decode_seq;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
    logic [4:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT, INST_CAP=32
  logic        rstn, en, ld_we, out_valid, out_ready, busy, halted, err;
  logic [4:0]  ld_addr, pc;
  logic [11:0] ld_data;
  logic [3:0]  op;
  logic [7:0]  data;

  // small DUT, INST_CAP=4, for jump/wrap
  logic        s_rstn, s_en, s_ld_we, s_valid, s_ready, s_busy, s_halted, s_err;
  logic [1:0]  s_ld_addr, s_pc;
  logic [11:0] s_ld_data;
  logic [3:0]  s_op;
  logic [7:0]  s_data;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t q4[$];

  fetch_decode_seq #(.INST_CAP(32)) dut (
    .clk(clk), .rstn(rstn), .en(en), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .data(data), .pc(pc), .busy(busy), .halted(halted), .err(err));

  fetch_decode_seq #(.INST_CAP(4)) dut4 (
    .clk(clk), .rstn(s_rstn), .en(s_en), .ld_we(s_ld_we), .ld_addr(s_ld_addr),
    .ld_data(s_ld_data), .out_valid(s_valid), .out_ready(s_ready),
    .op(s_op), .data(s_data), .pc(s_pc), .busy(s_busy), .halted(s_halted), .err(s_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [11:0] w);
    ld_we = 1'b1; ld_addr = a; ld_data = w;
    tick(1);
    ld_we = 1'b0;
  endtask

  task automatic s_load(input logic [1:0] a, input logic [11:0] w);
    s_ld_we = 1'b1; s_ld_addr = a; s_ld_data = w;
    tick(1);
    s_ld_we = 1'b0;
  endtask

  task automatic pulse_en();
    en = 1'b1;
    tick(1);
    en = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int k;
    k = 0;
    while (!halted && k < 40) begin
      tick(1);
      k++;
    end
    chk(name, 32'(halted), 32'd1);
  endtask

  task automatic push_prog();
    q.push_back('{op: 4'h1, data: 8'h11, pc: 5'd0});
    q.push_back('{op: 4'h2, data: 8'h22, pc: 5'd1});
  endtask

  // scoreboard monitors: one pop per accepted output
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got op=%0h data=%0h pc=%0d want none", op, data, pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({op, data, pc} !== e) begin
          n_bad++;
          $display("FAIL out_word: got op=%0h data=%0h pc=%0d want op=%0h data=%0h pc=%0d",
                   op, data, pc, e.op, e.data, e.pc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (s_rstn && s_valid && s_ready) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out4: got op=%0h data=%0h pc=%0d want none", s_op, s_data, s_pc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if ({s_op, s_data, 3'b000, s_pc} !== e) begin
          n_bad++;
          $display("FAIL out_word4: got op=%0h data=%0h pc=%0d want op=%0h data=%0h pc=%0d",
                   s_op, s_data, s_pc, e.op, e.data, e.pc);
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b0;
    s_rstn = 1'b0; s_en = 1'b0; s_ld_we = 1'b0; s_ld_addr = '0; s_ld_data = '0; s_ready = 1'b0;
    #12;
    chk("rst_valid",  32'(out_valid), 0);
    chk("rst_pc",     32'(pc), 0);
    chk("rst_opdata", {20'd0, op, data}, 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_err",    32'(err), 0);
    tick(1);
    rstn = 1'b1; s_rstn = 1'b1;

    // sequential run
    load(5'd0, {4'h1, 8'h11});
    load(5'd1, {4'h2, 8'h22});
    load(5'd2, {4'hF, 8'h00});
    out_ready = 1'b1;
    push_prog();
    pulse_en();
    chk("seq_busy", 32'(busy), 1);
    tick(2);
    chk("seq_first_valid", 32'(out_valid), 1);
    tick(1);
    chk("seq_gap_valid", 32'(out_valid), 0);
    chk("seq_pc_adv", 32'(pc), 1);
    tick(2);
    chk("seq_second_valid", 32'(out_valid), 1);
    tick(3);
    chk("seq_halted", 32'(halted), 1);
    chk("seq_halt_busy", 32'(busy), 0);
    chk("seq_halt_pc", 32'(pc), 2);

    // backpressure, with a write attempted while busy
    out_ready = 1'b0;
    push_prog();
    pulse_en();
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_frozen", {14'd0, out_valid, op, data, pc}, {14'd0, 1'b1, 4'h1, 8'h11, 5'd0});
      if (i == 1) begin
        chk("gate_busy", 32'(busy), 1);
        ld_we = 1'b1; ld_addr = 5'd0; ld_data = {4'h3, 8'h33};
      end
      tick(1);
      ld_we = 1'b0;
    end
    out_ready = 1'b1;
    tick(1);
    chk("bp_pc_on_hs", 32'(pc), 1);
    chk("bp_valid_drop", 32'(out_valid), 0);
    wait_halt("bp_halt");

    // readback: the gated write must not have landed
    push_prog();
    pulse_en();
    wait_halt("gate_halt");
    chk("gate_err", 32'(err), 0);

    // bad jump target
    load(5'd0, {4'hE, 8'h40});
    pulse_en();
    wait_halt("badjmp_halt");
    chk("badjmp_err", 32'(err), 1);
    chk("badjmp_pc", 32'(pc), 0);

    // restart with write+en on the same edge; err stays sticky
    push_prog();
    ld_we = 1'b1; ld_addr = 5'd0; ld_data = {4'h1, 8'h11}; en = 1'b1;
    tick(1);
    ld_we = 1'b0; en = 1'b0;
    chk("err_sticky_run", 32'(err), 1);
    chk("restart_halted", 32'(halted), 0);
    wait_halt("restart_halt");
    chk("err_sticky_halt", 32'(err), 1);

    // async reset while holding an output
    out_ready = 1'b0;
    pulse_en();
    tick(2);
    chk("hold_valid", {19'd0, out_valid, op, data}, {19'd0, 1'b1, 4'h1, 8'h11});
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid",  32'(out_valid), 0);
    chk("arst_opdata", {20'd0, op, data}, 0);
    chk("arst_pc",     32'(pc), 0);
    chk("arst_err",    32'(err), 0);
    chk("arst_busy",   32'(busy), 0);
    tick(1);
    rstn = 1'b1;
    tick(2);
    chk("arst_idle", {30'd0, busy, halted}, 0);

    // jump and wrap on the 4-deep instance
    s_load(2'd0, {4'h1, 8'hA0});
    s_load(2'd1, {4'hE, 8'h03});
    s_load(2'd2, {4'hF, 8'h00});
    s_load(2'd3, {4'h3, 8'h33});
    q4.push_back('{op: 4'h1, data: 8'hA0, pc: 5'd0});
    q4.push_back('{op: 4'h3, data: 8'h33, pc: 5'd3});
    q4.push_back('{op: 4'h1, data: 8'hA0, pc: 5'd0});
    s_ready = 1'b1;
    s_en = 1'b1;
    tick(1);
    s_en = 1'b0;
    for (int k = 0; k < 60 && q4.size() != 0; k++) tick(1);
    s_ready = 1'b0;
    chk("wrap_drained", q4.size(), 0);
    chk("wrap_err", 32'(s_err), 0);
    s_rstn = 1'b0;
    tick(1);

    chk("main_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
